data_inf_partition_gen: RTL and testbench

- Generalised burst partitioner for the AXI4 packet-partition path.
- Accepts one command {id, addr, length}, splits it into chunks of a run-time length P, and pushes chunk descriptors into an internal FIFO.
- Each descriptor carries a sub-id and a last flag. Gating on a per-chunk partition pulse is optional.
- After the FIFO drains, issues a completion handshake reporting id and chunk count.

---
 rtl/data_inf_partition_gen.sv | 178 +++++++++++++++++
 tb/tb_data_inf_partition_gen.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_inf_partition_gen.sv
// rtl/data_inf_partition_gen.sv - burst partitioner with descriptor FIFO and completion handshake
`timescale 1ns/1ps
module data_inf_partition_gen #(
    parameter int LSIZE      = 8,
    parameter int ASIZE      = 16,
    parameter int IDSIZE     = 4,
    parameter int SUBID_W    = 4,
    parameter int ADDR_STEP  = 1,
    parameter int DEPTH      = 8,
    parameter int GATE_PULSE = 1
) (
    input  logic                                       clock,
    input  logic                                       rst_n,
    input  logic [LSIZE-1:0]                           cfg_plen,
    input  logic                                       in_valid,
    output logic                                       in_ready,
    input  logic [IDSIZE+ASIZE+LSIZE-1:0]              in_data,
    output logic                                       out_valid,
    input  logic                                       out_ready,
    output logic [IDSIZE+SUBID_W+ASIZE+LSIZE:0]        out_data,
    output logic                                       pp_valid,
    input  logic                                       pp_ready,
    output logic                                       done_valid,
    input  logic                                       done_ready,
    output logic [IDSIZE+LSIZE:0]                      done_data,
    output logic                                       busy
);
    localparam int OW = IDSIZE + SUBID_W + ASIZE + LSIZE + 1;
    localparam int AW = $clog2(DEPTH);
    localparam logic [ASIZE-1:0] STEP  = ASIZE'(ADDR_STEP);
    localparam logic [LSIZE:0]   ONE_L = (LSIZE+1)'(1);

    typedef enum logic [2:0] {IDLE, LOCK, WAT_PP, PUSH, DRAIN, DONE} state_t;

    state_t               state_q;
    logic [IDSIZE-1:0]    id_q;
    logic [ASIZE-1:0]     addr_q;
    logic [LSIZE:0]       rem_q;
    logic [LSIZE-1:0]     plen_q;
    logic [SUBID_W-1:0]   subid_q;
    logic [LSIZE-1:0]     cnt_q;
    logic                 last_q;
    logic                 in_ready_q;
    logic                 pp_valid_q;
    logic                 done_valid_q;
    logic [IDSIZE+LSIZE:0] done_data_q;

    logic [OW-1:0]        mem_q [DEPTH];
    logic [AW:0]          wr_ptr_q;
    logic [AW:0]          rd_ptr_q;

    logic [AW:0]          fifo_cnt;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 wr_en;
    logic                 rd_en;
    logic                 drained;
    logic [OW-1:0]        wr_data;
    logic [LSIZE:0]       p_ext;
    logic [LSIZE:0]       rem_after;

    // P is kept one bit wider so cfg_plen = all-ones gives a chunk larger than any length
    assign p_ext      = {1'b0, plen_q} + ONE_L;
    assign rem_after  = rem_q - p_ext;

    // Full is judged on the pointers before any same-cycle read, so a read never frees a slot early
    assign fifo_cnt   = wr_ptr_q - rd_ptr_q;
    assign fifo_full  = (fifo_cnt == (AW+1)'(DEPTH));
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign rd_en      = !fifo_empty && out_ready;
    assign wr_en      = (state_q == PUSH) && !fifo_full;
    assign drained    = fifo_empty || ((fifo_cnt == (AW+1)'(1)) && rd_en);
    assign wr_data    = {id_q, subid_q, addr_q, (last_q ? rem_q[LSIZE-1:0] : plen_q), last_q};

    assign out_valid  = !fifo_empty;
    assign out_data   = mem_q[rd_ptr_q[AW-1:0]];
    assign in_ready   = in_ready_q;
    assign pp_valid   = pp_valid_q;
    assign done_valid = done_valid_q;
    assign done_data  = done_data_q;
    assign busy       = (state_q != IDLE);

    // Command sequencing: accept, split into chunks, wait for drain, report completion
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            id_q         <= '0;
            addr_q       <= '0;
            rem_q        <= '0;
            plen_q       <= '0;
            subid_q      <= '0;
            cnt_q        <= '0;
            last_q       <= 1'b0;
            in_ready_q   <= 1'b0;
            pp_valid_q   <= 1'b0;
            done_valid_q <= 1'b0;
            done_data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        id_q       <= in_data[IDSIZE+ASIZE+LSIZE-1 -: IDSIZE];
                        addr_q     <= in_data[ASIZE+LSIZE-1 -: ASIZE];
                        rem_q      <= {1'b0, in_data[LSIZE-1:0]};
                        plen_q     <= cfg_plen;
                        subid_q    <= '0;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= LOCK;
                    end else begin
                        in_ready_q <= 1'b1;
                    end
                end
                LOCK: begin
                    last_q <= (rem_q < p_ext);
                    if (GATE_PULSE != 0) begin
                        pp_valid_q <= 1'b1;
                        state_q    <= WAT_PP;
                    end else begin
                        state_q    <= PUSH;
                    end
                end
                WAT_PP: begin
                    if (pp_valid_q && pp_ready) begin
                        pp_valid_q <= 1'b0;
                        state_q    <= PUSH;
                    end
                end
                PUSH: begin
                    if (!fifo_full) begin
                        rem_q   <= rem_after;
                        addr_q  <= addr_q + STEP * ASIZE'(p_ext);
                        subid_q <= subid_q + SUBID_W'(1);
                        cnt_q   <= cnt_q + LSIZE'(1);
                        last_q  <= (rem_after < p_ext);
                        if (last_q) begin
                            state_q <= DRAIN;
                        end else if (GATE_PULSE != 0) begin
                            pp_valid_q <= 1'b1;
                            state_q    <= WAT_PP;
                        end
                    end
                end
                DRAIN: begin
                    if (drained) begin
                        done_valid_q <= 1'b1;
                        done_data_q  <= {id_q, ({1'b0, cnt_q} - ONE_L)};
                        state_q      <= DONE;
                    end
                end
                DONE: begin
                    if (done_ready) begin
                        done_valid_q <= 1'b0;
                        in_ready_q   <= 1'b1;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Descriptor FIFO pointers; the extra MSB separates full from empty
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (rd_en) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    // Descriptor storage; contents are meaningless once the pointers are reset
    always_ff @(posedge clock) begin
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end
endmodule

// File: tb/tb_data_inf_partition_gen.sv
// tb/tb_data_inf_partition_gen.sv - directed self-checking bench for data_inf_partition_gen
`timescale 1ns/1ps
module tb_data_inf_partition_gen;
    localparam int LIMIT = 2000;

    logic        clock;
    logic        rst_n;

    logic [9:0]  g_cfg_plen;
    logic        g_in_valid, g_in_ready;
    logic [29:0] g_in_data;
    logic        g_out_valid, g_out_ready;
    logic [34:0] g_out_data;
    logic        g_pp_valid, g_pp_ready;
    logic        g_done_valid, g_done_ready;
    logic [14:0] g_done_data;
    logic        g_busy;

    logic [9:0]  b_cfg_plen;
    logic        b_in_valid, b_in_ready;
    logic [29:0] b_in_data;
    logic        b_out_valid, b_out_ready;
    logic [34:0] b_out_data;
    logic        b_pp_valid, b_pp_ready;
    logic        b_done_valid, b_done_ready;
    logic [14:0] b_done_data;
    logic        b_busy;

    int          tests = 0;
    int          fails = 0;
    int          g_npp;
    logic [14:0] g_done_cap;
    logic [14:0] b_done_cap;
    logic [34:0] g_q[$];
    logic [34:0] b_q[$];

    data_inf_partition_gen #(
        .LSIZE(10), .ASIZE(16), .IDSIZE(4), .SUBID_W(4),
        .ADDR_STEP(1), .DEPTH(8), .GATE_PULSE(1)
    ) u_g (
        .clock(clock), .rst_n(rst_n), .cfg_plen(g_cfg_plen),
        .in_valid(g_in_valid), .in_ready(g_in_ready), .in_data(g_in_data),
        .out_valid(g_out_valid), .out_ready(g_out_ready), .out_data(g_out_data),
        .pp_valid(g_pp_valid), .pp_ready(g_pp_ready),
        .done_valid(g_done_valid), .done_ready(g_done_ready), .done_data(g_done_data),
        .busy(g_busy)
    );

    data_inf_partition_gen #(
        .LSIZE(10), .ASIZE(16), .IDSIZE(4), .SUBID_W(4),
        .ADDR_STEP(1), .DEPTH(2), .GATE_PULSE(0)
    ) u_b (
        .clock(clock), .rst_n(rst_n), .cfg_plen(b_cfg_plen),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .pp_valid(b_pp_valid), .pp_ready(b_pp_ready),
        .done_valid(b_done_valid), .done_ready(b_done_ready), .done_data(b_done_data),
        .busy(b_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [34:0] gd(input int id, input int sub, input int addr,
                                       input int clen, input bit last);
        return {id[3:0], sub[3:0], addr[15:0], clen[9:0], last};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic g_cmd(input logic [3:0] id, input logic [15:0] addr,
                         input logic [9:0] len, input logic [9:0] plen);
        int cyc = 0;
        @(negedge clock);
        g_cfg_plen = plen;
        g_in_data  = {id, addr, len};
        g_in_valid = 1'b1;
        while (!g_in_ready && cyc < LIMIT) begin
            @(negedge clock);
            cyc++;
        end
        chk("g_accept_timeout", cyc >= LIMIT, 0);
        @(posedge clock);
        #1;
        g_in_valid = 1'b0;
        g_cfg_plen = 10'd7;
    endtask

    task automatic g_run(input bit hs);
        int cyc = 0;
        bit stop = 0;
        g_q.delete();
        g_npp = 0;
        g_out_ready = 1'b1;
        while (!stop) begin
            @(negedge clock);
            g_pp_ready = g_pp_valid;
            if (g_pp_valid) g_npp++;
            if (g_out_valid) g_q.push_back(g_out_data);
            if (g_done_valid) stop = 1;
            cyc++;
            if (cyc >= LIMIT) stop = 1;
        end
        g_pp_ready = 1'b0;
        chk("g_run_timeout", cyc >= LIMIT, 0);
        chk("g_done_after_empty", g_out_valid, 0);
        g_done_cap = g_done_data;
        if (hs) begin
            g_done_ready = 1'b1;
            @(posedge clock);
            #1;
            g_done_ready = 1'b0;
        end
    endtask

    task automatic g_pp_hs();
        int cyc = 0;
        @(negedge clock);
        while (!g_pp_valid && cyc < LIMIT) begin
            @(negedge clock);
            cyc++;
        end
        chk("g_pp_timeout", cyc >= LIMIT, 0);
        g_pp_ready = 1'b1;
        @(posedge clock);
        #1;
        g_pp_ready = 1'b0;
    endtask

    initial begin
        int cyc;
        bit stop;
        rst_n = 1'b0;
        g_cfg_plen = '0; g_in_valid = 0; g_in_data = '0; g_out_ready = 0;
        g_pp_ready = 0; g_done_ready = 0;
        b_cfg_plen = '0; b_in_valid = 0; b_in_data = '0; b_out_ready = 0;
        b_pp_ready = 0; b_done_ready = 0;

        // reset values
        repeat (3) @(posedge clock);
        #1;
        chk("rst_in_ready", g_in_ready, 0);
        chk("rst_out_valid", g_out_valid, 0);
        chk("rst_pp_valid", g_pp_valid, 0);
        chk("rst_done_valid", g_done_valid, 0);
        chk("rst_done_data", g_done_data, 0);
        chk("rst_busy", g_busy, 0);
        chk("rst_b_out_valid", b_out_valid, 0);
        @(negedge clock);
        rst_n = 1'b1;
        @(posedge clock);
        #1;
        chk("rel_in_ready", g_in_ready, 1);
        chk("rel_b_in_ready", b_in_ready, 1);

        // multi-chunk gated command
        g_cmd(4'd3, 16'h0100, 10'd299, 10'd127);
        g_run(1);
        chk("t1_count", g_q.size(), 3);
        chk("t1_d0", g_q[0], gd(3, 0, 'h100, 127, 0));
        chk("t1_d1", g_q[1], gd(3, 1, 'h180, 127, 0));
        chk("t1_d2", g_q[2], gd(3, 2, 'h200, 43, 1));
        chk("t1_npp", g_npp, 3);
        chk("t1_done", g_done_cap, {4'd3, 11'd2});

        // single chunk
        g_cmd(4'd5, 16'h1234, 10'd50, 10'd127);
        g_run(1);
        chk("t2_count", g_q.size(), 1);
        chk("t2_d0", g_q[0], gd(5, 0, 'h1234, 50, 1));
        chk("t2_npp", g_npp, 1);
        chk("t2_done", g_done_cap, {4'd5, 11'd0});

        // exact multiple of P
        g_cmd(4'd7, 16'h0000, 10'd255, 10'd127);
        g_run(1);
        chk("t3_count", g_q.size(), 2);
        chk("t3_d0", g_q[0], gd(7, 0, 'h0, 127, 0));
        chk("t3_d1", g_q[1], gd(7, 1, 'h80, 127, 1));
        chk("t3_done", g_done_cap, {4'd7, 11'd1});

        // all-ones cfg_plen forces a single chunk
        g_cmd(4'd8, 16'hFFF0, 10'd1023, 10'd1023);
        g_run(1);
        chk("t4_count", g_q.size(), 1);
        chk("t4_d0", g_q[0], gd(8, 0, 'hFFF0, 1023, 1));
        chk("t4_done", g_done_cap, {4'd8, 11'd0});

        // completion held while done_ready stays low
        g_cmd(4'd1, 16'h0500, 10'd10, 10'd127);
        g_run(0);
        chk("t5_done", g_done_cap, {4'd1, 11'd0});
        g_cfg_plen = 10'd127;
        g_in_data  = {4'd2, 16'h0600, 10'd5};
        g_in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk("t5_hold_done_valid", g_done_valid, 1);
            chk("t5_hold_in_ready", g_in_ready, 0);
            chk("t5_hold_busy", g_busy, 1);
        end
        g_done_ready = 1'b1;
        @(negedge clock);
        g_done_ready = 1'b0;
        chk("t5_after_hs_done_valid", g_done_valid, 0);
        chk("t5_after_hs_in_ready", g_in_ready, 1);
        chk("t5_after_hs_not_accepted", g_busy, 0);
        @(negedge clock);
        chk("t5_accepted_busy", g_busy, 1);
        chk("t5_accepted_in_ready", g_in_ready, 0);
        g_in_valid = 1'b0;
        g_run(1);
        chk("t5_count", g_q.size(), 1);
        chk("t5_d0", g_q[0], gd(2, 0, 'h600, 5, 1));
        chk("t5_done2", g_done_cap, {4'd2, 11'd0});

        // backpressure on the ungated depth-2 instance
        @(negedge clock);
        b_cfg_plen  = 10'd63;
        b_in_data   = {4'd9, 16'h4000, 10'd1023};
        b_in_valid  = 1'b1;
        b_out_ready = 1'b0;
        @(negedge clock);
        b_in_valid = 1'b0;
        b_cfg_plen = 10'd5;
        chk("t6_busy", b_busy, 1);
        repeat (20) @(negedge clock);
        chk("t6_stall_out_valid", b_out_valid, 1);
        chk("t6_stall_head", b_out_data, gd(9, 0, 'h4000, 63, 0));
        chk("t6_stall_done_valid", b_done_valid, 0);
        chk("t6_stall_busy", b_busy, 1);
        chk("t6_stall_in_ready", b_in_ready, 0);
        b_out_ready = 1'b1;
        b_q.delete();
        cyc = 0;
        stop = 0;
        while (!stop) begin
            if (b_out_valid) b_q.push_back(b_out_data);
            if (b_done_valid) stop = 1;
            else begin
                @(negedge clock);
                cyc++;
                if (cyc >= LIMIT) stop = 1;
            end
        end
        chk("t6_timeout", cyc >= LIMIT, 0);
        chk("t6_done_after_empty", b_out_valid, 0);
        b_done_cap = b_done_data;
        chk("t6_count", b_q.size(), 16);
        for (int i = 0; i < 16; i++)
            chk("t6_desc", b_q[i], gd(9, i, 'h4000 + 64 * i, 63, i == 15));
        chk("t6_done", b_done_cap, {4'd9, 11'd15});
        b_done_ready = 1'b1;
        @(negedge clock);
        b_done_ready = 1'b0;
        b_out_ready  = 1'b0;

        // reset in PUSH with three descriptors queued
        g_out_ready = 1'b0;
        g_cmd(4'd2, 16'h0010, 10'd255, 10'd31);
        repeat (4) g_pp_hs();
        chk("t7_pre_out_valid", g_out_valid, 1);
        chk("t7_pre_head", g_out_data, gd(2, 0, 'h10, 31, 0));
        rst_n = 1'b0;
        #1;
        chk("t7_rst_out_valid", g_out_valid, 0);
        chk("t7_rst_pp_valid", g_pp_valid, 0);
        chk("t7_rst_done_valid", g_done_valid, 0);
        chk("t7_rst_busy", g_busy, 0);
        chk("t7_rst_in_ready", g_in_ready, 0);
        repeat (2) @(negedge clock);
        rst_n = 1'b1;
        g_cmd(4'd6, 16'h0020, 10'd20, 10'd127);
        g_run(1);
        chk("t7_count", g_q.size(), 1);
        chk("t7_d0", g_q[0], gd(6, 0, 'h20, 20, 1));
        chk("t7_done", g_done_cap, {4'd6, 11'd0});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
